data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the single data bus (addr/mode/reqw/reqs/data) between the core (master 0) and a DMA engine (master 1).
//  Core requests pass through combinationally. The losing master sees m*_wait; the core treats wait exactly like a stall (PC held).
//  Reads occupy 2 cycles (setup + sample), matching the core's LW stall. Writes occupy 1 cycle.
//  Sits between the datapath/DMA and the top-level bus wrapper, which owns the tri-state on data_bus_data.
// PARAMETERS
//  STARVE_LIMIT  8  contended cycles a DMA request may be denied before it is force-granted (0 = DMA wins every contention)
// PORTS
//  clk           in   1   system clock, rising edge
//  reset         in   1   asynchronous, active-high reset
//  m0_addr       in   32  core address
//  m0_mode       in   2   core mode: 00 idle, 01 read, 10 write, 11 treated as idle
//  m0_reqw       in   2   core access width
//  m0_reqs       in   1   core signed-load request
//  m0_wdata      in   32  core write data
//  m0_rdata      out  32  core read data, valid while m0_ready=1 on a read
//  m0_ready      out  1   core transfer completes this cycle
//  m0_wait       out  1   core request pending but not served this cycle
//  m1_addr, m1_mode, m1_reqw, m1_reqs, m1_wdata   in   32/2/2/1/32   DMA request, same encoding as the m0_* inputs
//  m1_rdata, m1_ready, m1_wait                    out  32/1/1        DMA response, same meaning as the m0_* outputs
//  bus_addr      out  32  data bus address
//  bus_mode      out  2   data bus mode
//  bus_reqw      out  2   data bus width
//  bus_reqs      out  1   data bus signed flag
//  bus_wdata     out  32  write data to the wrapper
//  bus_wdata_oe  out  1   1 when bus_mode=10; the wrapper drives data_bus_data
//  bus_rdata     in   32  data_bus_data as sampled by the wrapper
// BEHAVIOUR
//  State: phase {ARB, HOLD}, owner (1b), last_grant (1b), starve_cnt ($clog2(STARVE_LIMIT+1) bits, saturating).
//  Reset values: phase=ARB, owner=0, last_grant=1, starve_cnt=0.
//  Reset outputs: bus_mode=00, bus_addr/bus_wdata/bus_reqw/bus_reqs=0, bus_wdata_oe=0, all m*_ready/m*_wait/m*_rdata=0.
//  Request: req_x = (mx_mode==01 || mx_mode==10).
//  ARB phase (winner chosen combinationally in the same cycle):
//   - Only one master requests: that master wins.
//   - Both request: m1 wins if starve_cnt==STARVE_LIMIT, else m0.
//   - Neither requests: idle bus, all outputs as at reset.
//   - The winner's request fields drive bus_* directly; the loser's mx_wait=1.
//   - Winner writes: winner ready=1 this cycle; phase stays ARB.
//   - Winner reads: ready=0 and wait=0 this cycle; owner<=winner; phase<=HOLD.
//  HOLD phase:
//   - owner's fields drive the bus; the owner must keep its request stable.
//   - owner ready=1, owner rdata=bus_rdata.
//   - The other master's wait=1 if it requests.
//   - phase<=ARB.
//   - If the owner drops its request in HOLD, the cycle still completes with ready=1; the data is undefined.
//  mX_rdata=0 whenever mX_ready=0 or the transfer is a write.
//  starve_cnt: +1 on each cycle req_1 is denied, saturating at STARVE_LIMIT; cleared to 0 in the cycle m1 wins in ARB.
//  last_grant <= winner on every ARB cycle with a winner.
//  Reset asserted mid-HOLD: the transfer aborts, no ready is issued, and the state returns to its reset values.
// CONFIGURATION
//  DBUS_ARB_RR_EN defined:
//   - Contention is resolved round-robin: the winner is the master != last_grant.
//   - starve_cnt and STARVE_LIMIT are unused; the parameter is kept for port/param compatibility.
//  DBUS_ARB_RR_EN undefined: core priority with starvation override, as above.
// STRUCTURE
//  dbus_pkg:
//   - localparams BUS_IDLE=2'b00, BUS_READ=2'b01, BUS_WRITE=2'b10.
//   - typedef enum {ARB, HOLD} arb_phase_t.
//   - typedef master id M_CORE=0, M_DMA=1.
//   - typedef struct bus_req_t {addr, mode, reqw, reqs, wdata}.
//  Sub-module arb_starve_counter: saturating counter with inc/clr inputs and an at_limit output; omitted under DBUS_ARB_RR_EN.
//  Request muxing and the phase FSM stay in data_bus_arbiter.
// TESTING
//  1. Core-only write: m0 addr 0x4000, mode 10, wdata 0x5 -> same cycle bus_mode=10, bus_wdata_oe=1, m0_ready=1, m0_wait=0.
//  2. Core-only read: m0 mode 01 addr 0x1000, bus_rdata=0xDEADBEEF -> cycle1 ready=0; cycle2 m0_ready=1, m0_rdata=0xDEADBEEF.
//  3. Contention: both masters write continuously, STARVE_LIMIT=3 -> m0 wins 3 cycles (m1_wait=1), m1 wins cycle 4, starve_cnt=0, m0_wait=1.
//  4. DMA read in HOLD while core requests a write -> m0_wait=1 in the HOLD cycle; core granted the following cycle.
//  5. Reset pulse during HOLD of an m1 read -> m1_ready never asserts; bus_mode=00; phase=ARB after reset.
//  6. With DBUS_ARB_RR_EN, continuous contention -> grants alternate 0,1,0,1 (writes); m0_wait high on alternate cycles.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and bus-mode encodings for the data bus arbiter.
// DBUS_ARB_RR_EN selects round-robin contention instead of core priority.
package dbus_pkg;

  localparam logic [1:0] BUS_IDLE  = 2'b00;
  localparam logic [1:0] BUS_READ  = 2'b01;
  localparam logic [1:0] BUS_WRITE = 2'b10;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_phase_t;

  typedef enum logic {
    M_CORE = 1'b0,
    M_DMA  = 1'b1
  } master_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  mode;
    logic [1:0]  reqw;
    logic        reqs;
    logic [31:0] wdata;
  } bus_req_t;

  // Mode 11 is treated as idle.
  function automatic logic is_req(input logic [1:0] mode);
    return (mode == BUS_READ) || (mode == BUS_WRITE);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of contended cycles a DMA request has been denied.
// Not instantiated when DBUS_ARB_RR_EN is defined.
module arb_starve_counter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign at_limit = (cnt_q == Limit);

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data bus arbiter: core (m0) and DMA (m1); reads hold the bus for a sample cycle.
// DBUS_ARB_RR_EN: round-robin contention; otherwise core priority with DMA starvation override.
module data_bus_arbiter
  import dbus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_mode,
  input  logic [1:0]  m0_reqw,
  input  logic        m0_reqs,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_wait,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_mode,
  input  logic [1:0]  m1_reqw,
  input  logic        m1_reqs,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_wait,
  output logic [31:0] bus_addr,
  output logic [1:0]  bus_mode,
  output logic [1:0]  bus_reqw,
  output logic        bus_reqs,
  output logic [31:0] bus_wdata,
  output logic        bus_wdata_oe,
  input  logic [31:0] bus_rdata
);

  arb_phase_t phase_q, phase_d;
  master_t    owner_q, owner_d;
  master_t    win, lose, other;
  bus_req_t   req [2];
  bus_req_t   bus_sel;
  logic [1:0] req_v;
  logic [1:0] ready;
  logic [1:0] m_wait;
  logic [31:0] rdata [2];
  logic       has_win;

  assign req[M_CORE] = '{addr: m0_addr, mode: m0_mode, reqw: m0_reqw, reqs: m0_reqs,
                         wdata: m0_wdata};
  assign req[M_DMA]  = '{addr: m1_addr, mode: m1_mode, reqw: m1_reqw, reqs: m1_reqs,
                         wdata: m1_wdata};
  assign req_v   = {is_req(m1_mode), is_req(m0_mode)};
  assign has_win = |req_v;

`ifdef DBUS_ARB_RR_EN
  master_t last_grant_q, last_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= M_DMA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (!reset && (phase_q == ARB) && has_win) begin
      last_grant_d = win;
    end
  end

  always_comb begin
    if (&req_v) begin
      win = master_t'(~last_grant_q);
    end else begin
      win = req_v[1] ? M_DMA : M_CORE;
    end
  end
`else
  logic at_limit;
  logic starve_inc, starve_clr;

  // A DMA request is denied exactly when it is told to wait.
  assign starve_inc = req_v[1] && m_wait[1];
  assign starve_clr = (phase_q == ARB) && has_win && (win == M_DMA);

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (clk),
    .reset   (reset),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .at_limit(at_limit)
  );

  always_comb begin
    if (&req_v) begin
      win = at_limit ? M_DMA : M_CORE;
    end else begin
      win = req_v[1] ? M_DMA : M_CORE;
    end
  end
`endif

  assign lose  = master_t'(~win);
  assign other = master_t'(~owner_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= ARB;
      owner_q <= M_CORE;
    end else begin
      phase_q <= phase_d;
      owner_q <= owner_d;
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    phase_d  = phase_q;
    owner_d  = owner_q;
    bus_sel  = '0;
    ready    = '0;
    m_wait   = '0;
    rdata[0] = '0;
    rdata[1] = '0;
    if (!reset) begin
      case (phase_q)
        ARB: begin
          if (has_win) begin
            bus_sel      = req[win];
            m_wait[lose] = req_v[lose];
            if (req[win].mode == BUS_WRITE) begin
              ready[win] = 1'b1;
            end else begin
              phase_d = HOLD;
              owner_d = win;
            end
          end
        end
        HOLD: begin
          bus_sel         = req[owner_q];
          ready[owner_q]  = 1'b1;
          rdata[owner_q]  = bus_rdata;
          m_wait[other]   = req_v[other];
          phase_d         = ARB;
        end
        default: phase_d = ARB;
      endcase
    end
  end

  assign bus_addr     = bus_sel.addr;
  assign bus_mode     = bus_sel.mode;
  assign bus_reqw     = bus_sel.reqw;
  assign bus_reqs     = bus_sel.reqs;
  assign bus_wdata    = bus_sel.wdata;
  assign bus_wdata_oe = (bus_sel.mode == BUS_WRITE);

  assign m0_ready = ready[0];
  assign m1_ready = ready[1];
  assign m0_wait  = m_wait[0];
  assign m1_wait  = m_wait[1];
  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter (STARVE_LIMIT=3), honours DBUS_ARB_RR_EN.
module tb_data_bus_arbiter;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_addr  [2];
  logic [1:0]  m_mode  [2];
  logic [1:0]  m_reqw  [2];
  logic        m_reqs  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_wait, m1_ready, m1_wait;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [1:0]  bus_mode, bus_reqw;
  logic        bus_reqs, bus_wdata_oe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_addr     (m_addr[0]),
    .m0_mode     (m_mode[0]),
    .m0_reqw     (m_reqw[0]),
    .m0_reqs     (m_reqs[0]),
    .m0_wdata    (m_wdata[0]),
    .m0_rdata    (m0_rdata),
    .m0_ready    (m0_ready),
    .m0_wait     (m0_wait),
    .m1_addr     (m_addr[1]),
    .m1_mode     (m_mode[1]),
    .m1_reqw     (m_reqw[1]),
    .m1_reqs     (m_reqs[1]),
    .m1_wdata    (m_wdata[1]),
    .m1_rdata    (m1_rdata),
    .m1_ready    (m1_ready),
    .m1_wait     (m1_wait),
    .bus_addr    (bus_addr),
    .bus_mode    (bus_mode),
    .bus_reqw    (bus_reqw),
    .bus_reqs    (bus_reqs),
    .bus_wdata   (bus_wdata),
    .bus_wdata_oe(bus_wdata_oe),
    .bus_rdata   (bus_rdata)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a pending read owner (-1 none), the DMA denial streak and the last grant.
  int pend   = -1;
  int streak = 0;
  int last   = 1;

  initial begin
    forever begin
      logic [31:0] e_addr, e_wdata;
      logic [1:0]  e_mode, e_reqw;
      logic        e_reqs;
      logic [1:0]  e_ready, e_wait;
      logic [31:0] e_rdata [2];
      int          r [2];
      int          w, o;
      @(negedge clk);
      e_addr = '0; e_wdata = '0; e_mode = '0; e_reqw = '0; e_reqs = 1'b0;
      e_ready = '0; e_wait = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      for (int i = 0; i < 2; i++) r[i] = (m_mode[i] == 2'b01 || m_mode[i] == 2'b10) ? 1 : 0;
      w = -1;
      if (reset) begin
        pend = -1; streak = 0; last = 1;
      end else if (pend >= 0) begin
        w = pend;
        e_ready[w] = 1'b1;
        e_rdata[w] = bus_rdata;
        o = 1 - w;
        e_wait[o] = r[o] != 0;
        if (o == 1 && r[1] != 0 && streak < L) streak++;
        pend = -1;
      end else begin
        if (r[0] != 0 && r[1] != 0) begin
`ifdef DBUS_ARB_RR_EN
          w = 1 - last;
`else
          w = (streak == L) ? 1 : 0;
`endif
        end else if (r[0] != 0) w = 0;
        else if (r[1] != 0) w = 1;
        if (w >= 0) begin
          if (m_mode[w] == 2'b10) e_ready[w] = 1'b1;
          else pend = w;
          e_wait[1-w] = r[1-w] != 0;
          last = w;
          if (w == 1) streak = 0;
          else if (r[1] != 0 && streak < L) streak++;
        end
      end
      if (w >= 0) begin
        e_addr = m_addr[w]; e_mode = m_mode[w]; e_reqw = m_reqw[w];
        e_reqs = m_reqs[w]; e_wdata = m_wdata[w];
      end
      check("bus", {bus_addr, bus_mode, bus_reqw, bus_reqs, bus_wdata, bus_wdata_oe},
            {e_addr, e_mode, e_reqw, e_reqs, e_wdata, e_mode == 2'b10});
      check("m0_resp", {m0_ready, m0_wait, m0_rdata}, {e_ready[0], e_wait[0], e_rdata[0]});
      check("m1_resp", {m1_ready, m1_wait, m1_rdata}, {e_ready[1], e_wait[1], e_rdata[1]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [1:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata);
    m_mode[i]  = mode;
    m_addr[i]  = addr;
    m_wdata[i] = wdata;
    m_reqw[i]  = 2'b10;
    m_reqs[i]  = (i == 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_win;
    reset = 1'b1;
    bus_rdata = '0;
    drive(0, 2'b00, 0, 0);
    drive(1, 2'b00, 0, 0);
    tick();
    drive(0, 2'b10, 32'h4000, 32'h5);
    sample();
    check("reset_bus_mode", bus_mode, 2'b00);
    check("reset_m0_ready", m0_ready, 1'b0);
    check("reset_oe", bus_wdata_oe, 1'b0);

    // Core-only write completes in the same cycle.
    tick();
    reset = 1'b0;
    sample();
    check("wr_bus_mode", bus_mode, 2'b10);
    check("wr_oe", bus_wdata_oe, 1'b1);
    check("wr_m0_ready", m0_ready, 1'b1);
    check("wr_m0_wait", m0_wait, 1'b0);
    check("wr_addr", bus_addr, 32'h4000);

    // Core-only read: setup cycle then sample cycle.
    tick();
    drive(0, 2'b01, 32'h1000, 0);
    bus_rdata = 32'hDEADBEEF;
    sample();
    check("rd1_ready", m0_ready, 1'b0);
    check("rd1_rdata", m0_rdata, 32'h0);
    tick();
    sample();
    check("rd2_ready", m0_ready, 1'b1);
    check("rd2_rdata", m0_rdata, 32'hDEADBEEF);

    // DMA solo write leaves last grant with the DMA.
    tick();
    drive(0, 2'b00, 0, 0);
    drive(1, 2'b10, 32'h2000, 32'h77);
    sample();
    check("m1wr_ready", m1_ready, 1'b1);
    check("m1wr_addr", bus_addr, 32'h2000);

    // Continuous write contention.
    tick();
    drive(0, 2'b10, 32'h100, 32'h1);
    drive(1, 2'b10, 32'h200, 32'h2);
    for (int k = 0; k < 5; k++) begin
      sample();
`ifdef DBUS_ARB_RR_EN
      exp_win = k % 2;
`else
      exp_win = (k == 3) ? 1 : 0;
`endif
      check("cont_m0_ready", m0_ready, exp_win == 0);
      check("cont_m1_wait", m1_wait, exp_win == 0);
      check("cont_m1_ready", m1_ready, exp_win == 1);
      check("cont_m0_wait", m0_wait, exp_win == 1);
      tick();
    end

    // DMA read with core write arriving during the sample cycle.
    drive(0, 2'b00, 0, 0);
    drive(1, 2'b01, 32'h300, 0);
    bus_rdata = 32'hCAFEF00D;
    sample();
    check("dmard1_ready", m1_ready, 1'b0);
    check("dmard1_m0_wait", m0_wait, 1'b0);
    tick();
    drive(0, 2'b10, 32'h400, 32'h9);
    sample();
    check("dmard2_m0_wait", m0_wait, 1'b1);
    check("dmard2_ready", m1_ready, 1'b1);
    check("dmard2_rdata", m1_rdata, 32'hCAFEF00D);
    check("dmard2_addr", bus_addr, 32'h300);
    tick();
    drive(1, 2'b00, 0, 0);
    sample();
    check("dmard3_m0_ready", m0_ready, 1'b1);
    check("dmard3_addr", bus_addr, 32'h400);

    // Reset during the sample cycle of a DMA read aborts it.
    tick();
    drive(0, 2'b00, 0, 0);
    drive(1, 2'b01, 32'h500, 0);
    sample();
    check("rst_hold1_ready", m1_ready, 1'b0);
    tick();
    reset = 1'b1;
    sample();
    check("rst_hold2_ready", m1_ready, 1'b0);
    check("rst_hold2_mode", bus_mode, 2'b00);
    tick();
    reset = 1'b0;
    drive(1, 2'b00, 0, 0);
    drive(0, 2'b10, 32'h600, 32'h3);
    sample();
    check("post_rst_m0_ready", m0_ready, 1'b1);
    check("post_rst_m1_ready", m1_ready, 1'b0);
    tick();
    drive(0, 2'b00, 0, 0);
    sample();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
